// File: rtl/spram_arbiter_pkg.sv
// spram_arbiter_pkg: shared state encodings, grant ids and SPRAM geometry for the SPRAM arbiter.
package spram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic GRANT_M0         = 1'b0;
    localparam logic GRANT_M1         = 1'b1;
    localparam int   SPRAM_WORDS      = 32768;
    localparam int   SPRAM_ADDR_OUT_W = 22;

    function automatic logic [3:0] wen_of(input logic we, input logic [3:0] sel);
        return we ? sel : 4'b0000;
    endfunction

endpackage

// File: rtl/spram_arbiter_if.sv
// spram_arbiter_if: one Wishbone-classic style master port (cyc&stb merged) into the SPRAM arbiter.
interface spram_arbiter_if #(
    parameter int ADDR_W = 15
);
    logic              cyc;
    logic              we;
    logic [3:0]        sel;
    logic [ADDR_W-1:0] adr;
    logic [31:0]       wdat;
    logic [31:0]       rdat;
    logic              ack;

    modport master (output cyc, we, sel, adr, wdat, input rdat, ack);
    modport slave  (input cyc, we, sel, adr, wdat, output rdat, ack);
endinterface

// File: rtl/spram_arbiter_rr_arb2.sv
// rr_arb2: two-way picker; a lone request wins, contention goes to m0 when fixed else to the master not served last.
module rr_arb2
    import spram_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       fixed_i,
    output logic       winner_o
);

    always_comb
        winner_o = (req_i == 2'b10) ? GRANT_M1 :
                   (req_i == 2'b11) ? (fixed_i ? GRANT_M0 : !last_i) : GRANT_M0;

endmodule

// File: rtl/spram_arbiter.sv
// spram_arbiter: serialises two masters onto one single-port SPRAM (1-cycle registered read), one access per 4 cycles.
module spram_arbiter
    import spram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = $clog2(SPRAM_WORDS),
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic                        clk,
    input  logic                        resetn,
    spram_arbiter_if.slave              m0,
    spram_arbiter_if.slave              m1,
    output logic [3:0]                  spram_wen_o,
    output logic [SPRAM_ADDR_OUT_W-1:0] spram_addr_o,
    output logic [31:0]                 spram_wdata_o,
    input  logic [31:0]                 spram_rdata_i,
    output logic                        grant_o,
    output logic                        busy_o
);

    state_t            state_q;
    logic              grant_q, last_q, we_q, ack0_q, ack1_q;
    logic [3:0]        wen_q;
    logic [ADDR_W-1:0] adr_q;
    logic [31:0]       wdat_q, rdat_q;
    logic              win, we_d, own_cyc;
    logic [3:0]        sel_d;
    logic [ADDR_W-1:0] adr_d;
    logic [31:0]       wdat_d;

    rr_arb2 u_arb (
        .req_i   ({m1.cyc, m0.cyc}),
        .last_i  (last_q),
        .fixed_i (PRIO_FIXED),
        .winner_o(win)
    );

    always_comb begin
        we_d    = win ? m1.we   : m0.we;
        sel_d   = win ? m1.sel  : m0.sel;
        adr_d   = win ? m1.adr  : m0.adr;
        wdat_d  = win ? m1.wdat : m0.wdat;
        own_cyc = grant_q ? m1.cyc : m0.cyc;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            grant_q <= GRANT_M0;
            last_q  <= GRANT_M1;
            we_q    <= 1'b0;
            wen_q   <= 4'b0000;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            wen_q  <= 4'b0000;
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (m0.cyc || m1.cyc) begin
                    grant_q <= win;
                    last_q  <= win;
                    we_q    <= we_d;
                    adr_q   <= adr_d;
                    wdat_q  <= wdat_d;
                    wen_q   <= wen_of(we_d, sel_d);
                    state_q <= ST_ISSUE;
                end
                ST_ISSUE: state_q <= ST_WAIT;
                ST_WAIT: begin
                    // access completes regardless; a master that dropped cyc simply gets no ack
                    if (!we_q) rdat_q <= spram_rdata_i;
                    ack0_q  <= own_cyc && (grant_q == GRANT_M0);
                    ack1_q  <= own_cyc && (grant_q == GRANT_M1);
                    state_q <= ST_RESP;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign spram_wen_o   = wen_q;
    assign spram_addr_o  = SPRAM_ADDR_OUT_W'(adr_q);
    assign spram_wdata_o = wdat_q;
    assign grant_o       = grant_q;
    assign busy_o        = state_q != ST_IDLE;
    assign m0.rdat       = rdat_q;
    assign m1.rdat       = rdat_q;
    assign m0.ack        = ack0_q;
    assign m1.ack        = ack1_q;

endmodule

// File: tb/tb_spram_arbiter.sv
// tb_spram_arbiter: directed + random traffic on a round-robin and a fixed-priority arbiter against a transaction-level model.
module tb_spram_arbiter;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    spram_arbiter_if #(.ADDR_W(15)) m0if (), m1if (), f0if (), f1if ();

    logic [3:0]  wen, wen_f;
    logic [21:0] addr, addr_f;
    logic [31:0] wdata, wdata_f;
    logic [31:0] rdata = 32'h0, rdata_f = 32'h0;
    logic        grant, grant_f, busy, busy_f;

    spram_arbiter #(.ADDR_W(15), .PRIO_FIXED(1'b0)) dut (
        .clk(clk), .resetn(resetn), .m0(m0if), .m1(m1if),
        .spram_wen_o(wen), .spram_addr_o(addr), .spram_wdata_o(wdata),
        .spram_rdata_i(rdata), .grant_o(grant), .busy_o(busy)
    );

    spram_arbiter #(.ADDR_W(15), .PRIO_FIXED(1'b1)) dut_f (
        .clk(clk), .resetn(resetn), .m0(f0if), .m1(f1if),
        .spram_wen_o(wen_f), .spram_addr_o(addr_f), .spram_wdata_o(wdata_f),
        .spram_rdata_i(rdata_f), .grant_o(grant_f), .busy_o(busy_f)
    );

    // SPRAM behavioural models: byte-lane writes, 1-cycle registered read
    bit [31:0] mem [32768];
    bit [31:0] mem_f [32768];
    bit [31:0] exp_mem [32768];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (wen[i]) mem[addr[14:0]][8*i +: 8] <= wdata[8*i +: 8];
        rdata <= mem[addr[14:0]];
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (wen_f[i]) mem_f[addr_f[14:0]][8*i +: 8] <= wdata_f[8*i +: 8];
        rdata_f <= mem_f[addr_f[14:0]];
    end

    logic [1:0]  cyc_v = 2'b00, we_v = 2'b00, fcyc = 2'b00;
    logic [3:0]  sel_v [2];
    logic [14:0] adr_v [2];
    logic [31:0] wdat_v [2];
    logic [31:0] rd_v [2];
    logic [1:0]  ack_v;

    assign m0if.cyc = cyc_v[0];  assign m1if.cyc = cyc_v[1];
    assign m0if.we  = we_v[0];   assign m1if.we  = we_v[1];
    assign m0if.sel = sel_v[0];  assign m1if.sel = sel_v[1];
    assign m0if.adr = adr_v[0];  assign m1if.adr = adr_v[1];
    assign m0if.wdat = wdat_v[0]; assign m1if.wdat = wdat_v[1];
    assign rd_v[0] = m0if.rdat;  assign rd_v[1] = m1if.rdat;
    assign ack_v = {m1if.ack, m0if.ack};

    assign f0if.cyc = fcyc[0];   assign f1if.cyc = fcyc[1];
    assign f0if.we  = 1'b0;      assign f1if.we  = 1'b0;
    assign f0if.sel = 4'hF;      assign f1if.sel = 4'hF;
    assign f0if.adr = 15'h0005;  assign f1if.adr = 15'h0006;
    assign f0if.wdat = 32'h0;    assign f1if.wdat = 32'h0;

    int checks = 0;
    int errors = 0;
    int model_last = 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic set_f(input int m, input logic we, input logic [3:0] sel, input logic [14:0] adr, input logic [31:0] wd);
        we_v[m] = we; sel_v[m] = sel; adr_v[m] = adr; wdat_v[m] = wd;
    endtask

    // one granted access seen from the IDLE cycle in which it is sampled up to the following IDLE cycle
    task automatic serve(input int m, input bit abort);
        int o = 1 - m;
        logic [31:0] exp_rd = exp_mem[adr_v[m]];
        if (we_v[m]) exp_mem[adr_v[m]] = merge(exp_mem[adr_v[m]], wdat_v[m], sel_v[m]);
        model_last = m;
        @(negedge clk);
        chk("issue_busy", 32'(busy), 32'(1));
        chk("issue_grant", 32'(grant), 32'(m));
        chk("issue_wen", 32'(wen), 32'(we_v[m] ? sel_v[m] : 4'h0));
        chk("issue_addr", 32'(addr), 32'(adr_v[m]));
        chk("issue_wdata", wdata, wdat_v[m]);
        @(negedge clk);
        chk("wait_wen", 32'(wen), 32'(0));
        chk("wait_ack", 32'(ack_v), 32'(0));
        if (abort) cyc_v[m] = 1'b0;
        @(negedge clk);
        chk("resp_ack_own", 32'(ack_v[m]), 32'(!abort));
        chk("resp_ack_other", 32'(ack_v[o]), 32'(0));
        chk("resp_busy", 32'(busy), 32'(1));
        if (!we_v[m] && !abort) chk("resp_rdat", rd_v[m], exp_rd);
        cyc_v[m] = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'(0));
        chk("idle_ack", 32'(ack_v), 32'(0));
    endtask

    task automatic txn(input bit v0, input bit v1, input bit abort_first);
        int w = (v0 && v1) ? (model_last == 1 ? 0 : 1) : (v1 ? 1 : 0);
        cyc_v = {v1, v0};
        serve(w, abort_first);
        if (v0 && v1) serve(1 - w, 1'b0);
    endtask

    initial begin
        set_f(0, 1'b0, 4'h0, 15'h0, 32'h0);
        set_f(1, 1'b0, 4'h0, 15'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(ack_v), 32'(0));
        chk("rst_wen", 32'(wen), 32'(0));
        chk("rst_addr", 32'(addr), 32'(0));
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_rdat", rd_v[0], 32'h0);
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        resetn = 1'b1;
        @(negedge clk);

        set_f(0, 1'b1, 4'hF, 15'h0010, 32'hDEADBEEF); txn(1'b1, 1'b0, 1'b0);
        set_f(0, 1'b0, 4'hF, 15'h0010, 32'h0);        txn(1'b1, 1'b0, 1'b0);
        chk("t1_rdat", rd_v[0], 32'hDEADBEEF);

        set_f(0, 1'b0, 4'hF, 15'h0010, 32'h0);
        set_f(1, 1'b1, 4'hF, 15'h0020, 32'hCAFEF00D);
        repeat (3) txn(1'b1, 1'b1, 1'b0);

        set_f(0, 1'b1, 4'hF, 15'h7FFF, 32'h11223344);  txn(1'b1, 1'b0, 1'b0);
        set_f(0, 1'b1, 4'b0100, 15'h7FFF, 32'h00AA0000); txn(1'b1, 1'b0, 1'b0);
        set_f(0, 1'b0, 4'hF, 15'h7FFF, 32'h0);         txn(1'b1, 1'b0, 1'b0);
        chk("t3_merge", rd_v[0], 32'h11AA3344);

        set_f(0, 1'b1, 4'h0, 15'h0010, 32'hFFFFFFFF); txn(1'b1, 1'b0, 1'b0);
        set_f(0, 1'b0, 4'hF, 15'h0010, 32'h0);        txn(1'b1, 1'b0, 1'b0);
        chk("sel0_keep", rd_v[0], 32'hDEADBEEF);

        set_f(1, 1'b1, 4'hF, 15'h0030, 32'h5A5AA5A5); txn(1'b0, 1'b1, 1'b1);
        set_f(0, 1'b0, 4'hF, 15'h0030, 32'h0);        txn(1'b1, 1'b0, 1'b0);
        chk("abort_commit", rd_v[0], 32'h5A5AA5A5);

        for (int n = 0; n < 40; n++) begin
            int v = $urandom_range(1, 3);
            for (int m = 0; m < 2; m++)
                set_f(m, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                      ($urandom_range(0, 7) == 0) ? 15'h7FFF : 15'($urandom_range(0, 7)), $urandom);
            txn(v[0], v[1], $urandom_range(0, 5) == 0);
        end

        set_f(0, 1'b1, 4'hF, 15'h0040, 32'h12345678);
        cyc_v = 2'b01;
        @(negedge clk);
        chk("mid_issue_wen", 32'(wen), 32'hF);
        #1 resetn = 1'b0;
        #1;
        chk("mid_rst_wen", 32'(wen), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_grant", 32'(grant), 32'(0));
        chk("mid_rst_addr", 32'(addr), 32'(0));
        chk("mid_rst_wdata", wdata, 32'h0);
        chk("mid_rst_rdat", rd_v[0], 32'h0);
        cyc_v = 2'b00;
        @(negedge clk);
        chk("mid_rst_ack", 32'(ack_v), 32'(0));
        resetn = 1'b1;
        model_last = 1;
        @(negedge clk);
        set_f(0, 1'b0, 4'hF, 15'h0040, 32'h0);
        set_f(1, 1'b0, 4'hF, 15'h0010, 32'h0);
        txn(1'b1, 1'b1, 1'b0);

        fcyc = 2'b11;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk("fx_ack0", 32'(f0if.ack), 32'(k % 4 == 3));
            chk("fx_ack1", 32'(f1if.ack), 32'(0));
            chk("fx_grant", 32'(grant_f), 32'(0));
        end
        fcyc[0] = 1'b0;
        for (int k = 16; k <= 20; k++) begin
            @(negedge clk);
            chk("fx_m1_ack", 32'(f1if.ack), 32'(k == 19));
            chk("fx_m1_grant", 32'(grant_f), 32'(k >= 17));
            if (k == 19) fcyc[1] = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
